// File: rtl/mash_pkg.sv
// Shared helpers for the MASH 1-1 modulator.
// Fraction width derivation and output code type.
package mash_pkg;

    function automatic int mash_fw(input int width, input int dac_bw);
        return width - dac_bw + 2;
    endfunction

    typedef logic signed [3:0] dac_code_t;

endpackage

// File: rtl/mash_stage.sv
// First-order error-feedback accumulator for the MASH cascade.
// Emits carry and new residue combinationally; stores residue on enable.
module mash_stage #(
    parameter int FW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [FW-1:0] addend,
    output logic          carry,
    output logic [FW-1:0] residue
);

    logic [FW-1:0] acc;
    logic [FW:0]   sum;

    assign sum     = {1'b0, acc} + {1'b0, addend};
    assign carry   = sum[FW];
    assign residue = sum[FW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= residue;
        end
    end

endmodule

// File: rtl/mash_1_1.sv
// MASH 1-1 delta-sigma modulator: wide unsigned samples in,
// narrow signed DAC codes out with 2nd-order noise shaping.
module mash_1_1
    import mash_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DAC_BW = 4
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic [WIDTH-1:0]  s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DAC_BW-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid
);

    localparam int FW = mash_fw(WIDTH, DAC_BW);

    generate
        if (DAC_BW < 3 || DAC_BW > WIDTH - 1) begin : g_bad_param
            $error("mash_1_1: DAC_BW out of range");
        end
    endgenerate

    logic [DAC_BW-3:0] int_part;
    logic [FW-1:0]     frac_part;
    logic              accept;
    logic              c1;
    logic              c2;
    logic              c2_d;
    logic [FW-1:0]     e1;
    logic [FW-1:0]     e2;
    logic [DAC_BW:0]   y_wide;

    assign int_part  = s_axis_data_tdata[WIDTH-1:FW];
    assign frac_part = s_axis_data_tdata[FW-1:0];
    assign accept    = s_axis_data_tvalid && s_axis_data_tready;

    mash_stage #(.FW(FW)) u_stage1 (
        .clk     (aclk),
        .rst     (arst),
        .en      (accept),
        .addend  (frac_part),
        .carry   (c1),
        .residue (e1)
    );

    // Stage 2 sees this sample's stage-1 residue, not the stored one.
    mash_stage #(.FW(FW)) u_stage2 (
        .clk     (aclk),
        .rst     (arst),
        .en      (accept),
        .addend  (e1),
        .carry   (c2),
        .residue (e2)
    );

    assign y_wide = {3'b000, int_part}
                  + {{DAC_BW{1'b0}}, c1}
                  + {{DAC_BW{1'b0}}, c2}
                  - {{DAC_BW{1'b0}}, c2_d};

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            s_axis_data_tready <= 1'b0;
            c2_d               <= 1'b0;
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
        end else begin
            s_axis_data_tready <= 1'b1;
            m_axis_data_tvalid <= accept;
            if (accept) begin
                c2_d              <= c2;
                m_axis_data_tdata <= y_wide[DAC_BW-1:0];
            end
        end
    end

`ifndef SYNTHESIS
    // y stays within [I-1, I+2], so the wide sum never overflows the code.
    always_ff @(posedge aclk) begin
        if (!arst && accept) begin
            assert (y_wide[DAC_BW] == y_wide[DAC_BW-1]);
        end
    end
`endif

    logic unused_e2;
    assign unused_e2 = ^e2;

endmodule

// File: tb/tb_mash_1_1.sv
// Directed bench for mash_1_1 (WIDTH=16, DAC_BW=4, FW=14).
module tb_mash_1_1;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [15:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [3:0]  m_tdata;
    logic        m_tvalid;

    int compared = 0;
    int mismatched = 0;

    localparam logic [3:0] PAT [4] = '{4'd0, 4'd1, 4'd1, 4'd0};

    always #5 aclk = ~aclk;

    mash_1_1 #(.WIDTH(16), .DAC_BW(4)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_data_tdata  (tdata),
        .s_axis_data_tvalid (tvalid),
        .s_axis_data_tready (tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid)
    );

    // Reset, release on a falling edge, then pass the edge where tready rises.
    task automatic apply_reset(input logic [15:0] d, input logic v);
        arst   = 1'b1;
        tdata  = d;
        tvalid = v;
        repeat (2) @(negedge aclk);
        arst = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        arst   = 1'b1;
        tdata  = 16'h2000;
        tvalid = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        compared++;
        if (tready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_tready: got %b expected 0", tready);
        end
        compared++;
        if (m_tvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_tvalid: got %b expected 0", m_tvalid);
        end
        compared++;
        if (m_tdata !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_tdata: got %0d expected 0", m_tdata);
        end
    endtask

    task automatic test_zero;
        apply_reset(16'h0000, 1'b1);
        compared++;
        if (tready !== 1'b1 || m_tvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_first_edge: tready=%b tvalid=%b expected 1/0",
                     tready, m_tvalid);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge aclk);
            #1;
            compared++;
            if (m_tvalid !== 1'b1 || m_tdata !== 4'd0) begin
                mismatched++;
                $display("FAIL zero_out[%0d]: got v=%b y=%0d expected v=1 y=0",
                         k, m_tvalid, m_tdata);
            end
        end
    endtask

    task automatic test_integer;
        apply_reset(16'h4000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(posedge aclk);
            #1;
            compared++;
            if (m_tvalid !== 1'b1 || m_tdata !== 4'd1) begin
                mismatched++;
                $display("FAIL integer_out[%0d]: got v=%b y=%0d expected v=1 y=1",
                         k, m_tvalid, m_tdata);
            end
        end
    endtask

    task automatic test_half;
        apply_reset(16'h2000, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(posedge aclk);
            #1;
            compared++;
            if (m_tvalid !== 1'b1 || m_tdata !== PAT[k % 4]) begin
                mismatched++;
                $display("FAIL half_out[%0d]: got v=%b y=%0d expected v=1 y=%0d",
                         k, m_tvalid, m_tdata, PAT[k % 4]);
            end
        end
    endtask

    task automatic test_sum(input logic [15:0] d, input int lo_y,
                            input int hi_y, input int target);
        int sum;
        int bad;
        int y;
        sum = 0;
        bad = 0;
        apply_reset(d, 1'b1);
        for (int k = 0; k < 16384; k++) begin
            @(posedge aclk);
            #1;
            y = int'($signed(m_tdata));
            if (m_tvalid !== 1'b1 || y < lo_y || y > hi_y) bad++;
            sum += y;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL sum_range_%h: %0d outputs outside [%0d,%0d] or invalid",
                     d, bad, lo_y, hi_y);
        end
        compared++;
        if (sum < target - 2 || sum > target + 2) begin
            mismatched++;
            $display("FAIL sum_mean_%h: got %0d expected %0d +-2", d, sum, target);
        end
    endtask

    task automatic test_gaps;
        int n;
        logic [3:0] last;
        logic exp_v;
        n    = 0;
        last = 4'd0;
        apply_reset(16'h2000, 1'b0);
        for (int k = 0; k < 16; k++) begin
            @(negedge aclk);
            exp_v  = (k % 2 == 0);
            tvalid = exp_v;
            @(posedge aclk);
            #1;
            compared++;
            if (m_tvalid !== exp_v) begin
                mismatched++;
                $display("FAIL gaps_tvalid[%0d]: got %b expected %b",
                         k, m_tvalid, exp_v);
            end
            if (exp_v) begin
                last = PAT[n % 4];
                n++;
            end
            compared++;
            if (m_tdata !== last) begin
                mismatched++;
                $display("FAIL gaps_tdata[%0d]: got %0d expected %0d",
                         k, m_tdata, last);
            end
        end
        tvalid = 1'b1;
    endtask

    task automatic test_reset_mid;
        apply_reset(16'h2000, 1'b1);
        repeat (6) @(posedge aclk);
        #1;
        compared++;
        if (m_tdata !== 4'd1 || m_tvalid !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_before: got v=%b y=%0d expected v=1 y=1",
                     m_tvalid, m_tdata);
        end
        #2;
        arst = 1'b1;
        #1;
        compared++;
        if (m_tdata !== 4'd0 || m_tvalid !== 1'b0 || tready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_async: got y=%0d v=%b rdy=%b expected 0/0/0",
                     m_tdata, m_tvalid, tready);
        end
        apply_reset(16'h2000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(posedge aclk);
            #1;
            compared++;
            if (m_tvalid !== 1'b1 || m_tdata !== PAT[k % 4]) begin
                mismatched++;
                $display("FAIL mid_restart[%0d]: got v=%b y=%0d expected v=1 y=%0d",
                         k, m_tvalid, m_tdata, PAT[k % 4]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_integer;
        test_half;
        test_sum(16'hFFFF, 2, 5, 65535);
        test_sum(16'h1234, -1, 2, 16'h1234);
        test_gaps;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
